// File: rtl/rfphoenix_dcache_tag.sv
// rfphoenix_dcache_tag
//   Tag store for a 4-way set-associative data cache with 64-byte lines.
//   Lookups are registered: a request sampled at one rising edge shows its
//   result (rdy/hit/rway/multihit) for the following cycle. Fills and line
//   invalidates update the store at the same edge. The lookup reads the
//   pre-update contents, so a same-edge fill is not visible until the next
//   lookup. inv_all starts a sweep that clears one set per cycle. All other
//   traffic is ignored while the sweep runs.
//
// Ports
//   clk, rst        clock / asynchronous active-high reset
//   req, adr        lookup request and address
//   rdy, hit, rway  lookup result valid, hit flag, lowest matching way
//   multihit        two or more ways matched (error flag)
//   wr, wadr, wway  tag fill: address and victim way
//   inv_line        invalidate ways whose tag matches wadr (beats wr)
//   inv_all, busy   start full sweep / sweep in progress

// One way of the tag store: tag array, valid bits and the tag comparator.
module rfphoenix_dcache_tag_way #(
  parameter int LINES = 64,
  parameter int TAGW  = 20,
  parameter int IW    = $clog2(LINES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   rd_idx_i,
  input  logic [TAGW-1:0] rd_tag_i,
  input  logic            wr_en_i,
  input  logic            inv_en_i,
  input  logic [IW-1:0]   wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i,
  input  logic            clr_en_i,
  input  logic [IW-1:0]   clr_idx_i,
  output logic            match_o
);
  // Tags carry no reset; only the valid bits are meaningful after reset.
  logic [TAGW-1:0]  tag_q [LINES];
  logic [LINES-1:0] vld_q;
  logic             inv_hit;

  always_ff @(posedge clk)
    if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;

  assign inv_hit = inv_en_i && (tag_q[wr_idx_i] == wr_tag_i);

  // clr comes only from the sweep, while wr/inv arrive only when idle,
  // so these branches never compete in practice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vld_q <= '0;
    else if (clr_en_i) vld_q[clr_idx_i] <= 1'b0;
    else if (inv_hit)  vld_q[wr_idx_i]  <= 1'b0;
    else if (wr_en_i)  vld_q[wr_idx_i]  <= 1'b1;
  end

  assign match_o = vld_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
endmodule

module rfphoenix_dcache_tag #(
  parameter int LINES = 64,
  parameter int TAGW  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] adr,
  output logic        rdy,
  output logic        hit,
  output logic [1:0]  rway,
  output logic        multihit,
  input  logic        wr,
  input  logic [31:0] wadr,
  input  logic [1:0]  wway,
  input  logic        inv_line,
  input  logic        inv_all,
  output logic        busy
);
  localparam int IW   = $clog2(LINES);
  localparam int WAYS = 4;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            clr;
  logic            rst_done_q;
  logic            idle, lk, fill, inval;
  logic [IW-1:0]   rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic [WAYS-1:0] match;
  logic [1:0]      enc;
  logic            multi;
  logic            rdy_q, hit_q, mh_q;
  logic [1:0]      rway_q;
  logic            unused_adr;

  assign unused_adr = ^{adr[5:0], wadr[5:0]};

  assign rd_idx = adr[6 +: IW];
  assign rd_tag = adr[31 -: TAGW];
  assign wr_idx = wadr[6 +: IW];
  assign wr_tag = wadr[31 -: TAGW];

  assign idle  = (state_q == IDLE);
  // The first edge after reset release never answers a lookup.
  assign lk    = req && idle && rst_done_q;
  assign inval = inv_line && idle;
  assign fill  = wr && idle && !inv_line;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    rfphoenix_dcache_tag_way #(.LINES(LINES), .TAGW(TAGW)) u_way (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_i  (rd_idx),
      .rd_tag_i  (rd_tag),
      .wr_en_i   (fill && (wway == 2'(w))),
      .inv_en_i  (inval),
      .wr_idx_i  (wr_idx),
      .wr_tag_i  (wr_tag),
      .clr_en_i  (clr),
      .clr_idx_i (cnt_q),
      .match_o   (match[w])
    );
  end

  // Lowest matching way wins; multi is set when more than one bit is set.
  always_comb begin
    enc = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (match[w]) enc = 2'(w);
  end
  assign multi = |(match & (match - WAYS'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (inv_all) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        clr   = 1'b1;
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == IW'(LINES-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rst_done_q <= 1'b0;
      rdy_q      <= 1'b0;
      hit_q      <= 1'b0;
      rway_q     <= '0;
      mh_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_done_q <= 1'b1;
      rdy_q      <= lk;
      hit_q      <= lk && (|match);
      rway_q     <= lk ? enc : 2'd0;
      mh_q       <= lk && multi;
    end
  end

  assign rdy      = rdy_q;
  assign hit      = hit_q;
  assign rway     = rway_q;
  assign multihit = mh_q;
  assign busy     = (state_q == SWEEP);
endmodule

// File: tb/tb_rfphoenix_dcache_tag.sv
module tb_rfphoenix_dcache_tag;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0, inv_line = 1'b0, inv_all = 1'b0;
  logic [31:0] adr = '0, wadr = '0;
  logic [1:0]  wway = '0;
  logic        rdy, hit, multihit, busy;
  logic [1:0]  rway;

  int tests = 0, fails = 0;

  rfphoenix_dcache_tag dut (
    .clk(clk), .rst(rst), .req(req), .adr(adr), .rdy(rdy), .hit(hit),
    .rway(rway), .multihit(multihit), .wr(wr), .wadr(wadr), .wway(wway),
    .inv_line(inv_line), .inv_all(inv_all), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain tag/valid tables, sweep treated as "all lines
  // gone now, outputs dead for 64 cycles".
  logic [19:0] mtag [4][64];
  bit          mval [4][64];
  int          busy_left = 0;
  bit          just_reset = 1'b1;
  logic        exp_rdy, exp_hit, exp_mh, exp_busy;
  logic [1:0]  exp_rway;

  task automatic mreset();
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 64; i++) mval[w][i] = 1'b0;
    busy_left  = 0;
    just_reset = 1'b1;
  endtask

  task automatic model_step();
    int n;
    int ix;
    exp_rdy = 0; exp_hit = 0; exp_rway = 0; exp_mh = 0;
    if (busy_left == 0 && req && !just_reset) begin
      exp_rdy = 1;
      n = 0;
      ix = int'(adr[11:6]);
      for (int w = 0; w < 4; w++)
        if (mval[w][ix] && mtag[w][ix] == adr[31:12]) begin
          if (n == 0) exp_rway = 2'(w);
          n++;
        end
      exp_hit = (n > 0);
      exp_mh  = (n > 1);
    end
    if (busy_left == 0) begin
      ix = int'(wadr[11:6]);
      if (inv_line) begin
        for (int w = 0; w < 4; w++)
          if (mtag[w][ix] == wadr[31:12]) mval[w][ix] = 1'b0;
      end else if (wr) begin
        mtag[wway][ix] = wadr[31:12];
        mval[wway][ix] = 1'b1;
      end
      if (inv_all) begin
        for (int w = 0; w < 4; w++)
          for (int i = 0; i < 64; i++) mval[w][i] = 1'b0;
        busy_left = 64;
      end
    end else begin
      busy_left--;
    end
    just_reset = 1'b0;
    exp_busy = (busy_left > 0);
  endtask

  // Step the model over the coming edge, take the edge, drop pulse inputs.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    req = 0; wr = 0; inv_line = 0; inv_all = 0;
  endtask

  function automatic logic [31:0] mka(int t, int i);
    return {20'(t), 6'(i), 6'($urandom_range(0, 63))};
  endfunction

  task automatic test_reset();
    rst = 1;
    mreset();
    @(posedge clk); #1;
    tests++;
    if ({rdy, hit, rway, multihit, busy} !== 6'b0) begin
      fails++; $display("FAIL reset_state got %b exp 000000", {rdy, hit, rway, multihit, busy});
    end
    rst = 0;
    just_reset = 1;
    req = 1; adr = 32'h0000_1040; cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b0) begin
      fails++; $display("FAIL first_edge_lookup got %b exp 0000", {rdy, hit, rway});
    end
    req = 1; adr = 32'h0000_1040; cyc();
    tests++;
    if ({rdy, hit, rway, multihit, busy} !== 6'b100000) begin
      fails++; $display("FAIL cold_miss got %b exp 100000", {rdy, hit, rway, multihit, busy});
    end
    cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b0) begin
      fails++; $display("FAIL idle_rdy got %b exp 0000", {rdy, hit, rway});
    end
  endtask

  task automatic test_fill_hit();
    wr = 1; wadr = 32'h1234_5080; wway = 2; cyc();
    req = 1; adr = 32'h1234_509C; cyc();
    tests++;
    if ({rdy, hit, rway, multihit, busy} !== 6'b111000) begin
      fails++; $display("FAIL fill_hit got %b exp 111000", {rdy, hit, rway, multihit, busy});
    end
    req = 1; adr = 32'h2234_5080; cyc();
    tests++;
    if ({rdy, hit, rway, multihit} !== 5'b10000) begin
      fails++; $display("FAIL tag_miss got %b exp 10000", {rdy, hit, rway, multihit});
    end
  endtask

  task automatic test_rbw();
    wr = 1; wadr = 32'h0ABC_D1C0; wway = 1;
    req = 1; adr = 32'h0ABC_D1C4; cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b1000) begin
      fails++; $display("FAIL rbw_same_cycle got %b exp 1000", {rdy, hit, rway});
    end
    req = 1; adr = 32'h0ABC_D1C4; cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b1101) begin
      fails++; $display("FAIL rbw_next_cycle got %b exp 1101", {rdy, hit, rway});
    end
  endtask

  task automatic test_multihit_inv();
    wr = 1; wadr = 32'h5555_5140; wway = 1; cyc();
    wr = 1; wadr = 32'h5555_5140; wway = 3; cyc();
    req = 1; adr = 32'h5555_5140; cyc();
    tests++;
    if ({rdy, hit, rway, multihit} !== 5'b11011) begin
      fails++; $display("FAIL multihit got %b exp 11011", {rdy, hit, rway, multihit});
    end
    inv_line = 1; wadr = 32'h5555_5140; cyc();
    req = 1; adr = 32'h5555_5140; cyc();
    tests++;
    if ({rdy, hit, multihit} !== 3'b100) begin
      fails++; $display("FAIL inv_line got %b exp 100", {rdy, hit, multihit});
    end
    // inv_line beats wr in the same cycle
    inv_line = 1; wr = 1; wadr = 32'h7777_7240; wway = 0; cyc();
    req = 1; adr = 32'h7777_7240; cyc();
    tests++;
    if ({rdy, hit} !== 2'b10) begin
      fails++; $display("FAIL inv_over_wr got %b exp 10", {rdy, hit});
    end
    // inv_line with a non-matching tag leaves the line alone
    wr = 1; wadr = 32'h7777_7240; wway = 0; cyc();
    inv_line = 1; wadr = 32'h8888_8240; cyc();
    req = 1; adr = 32'h7777_7240; cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b1100) begin
      fails++; $display("FAIL inv_miss got %b exp 1100", {rdy, hit, rway});
    end
  endtask

  task automatic test_sweep();
    int cnt = 0, guard = 0;
    for (int w = 0; w < 4; w++) begin
      wr = 1; wway = 2'(w); wadr = mka(32'hA0000 + w, 0);  cyc();
      wr = 1; wway = 2'(w); wadr = mka(32'hA0000 + w, 63); cyc();
    end
    req = 1; adr = mka(32'hA0002, 63); cyc();
    tests++;
    if ({rdy, hit, rway} !== 4'b1110) begin
      fails++; $display("FAIL pre_sweep_hit got %b exp 1110", {rdy, hit, rway});
    end
    inv_all = 1; cyc();
    while (busy === 1'b1 && guard < 200) begin
      cnt++; guard++;
      req = 1; adr = mka(32'hA0000 + $urandom_range(0, 3), 63);
      wr = 1; wadr = mka(32'hB0000, 0); inv_all = 1;
      cyc();
      tests++;
      if ({rdy, hit} !== 2'b00) begin
        fails++; $display("FAIL sweep_ignore got %b exp 00", {rdy, hit});
      end
    end
    tests++;
    if (cnt != 64) begin
      fails++; $display("FAIL sweep_len got %0d exp 64", cnt);
    end
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 2; k++) begin
        req = 1; adr = mka(32'hA0000 + w, k * 63); cyc();
        tests++;
        if ({rdy, hit, busy} !== 3'b100) begin
          fails++; $display("FAIL post_sweep w%0d got %b exp 100", w, {rdy, hit, busy});
        end
      end
  endtask

  task automatic test_reset_mid_sweep();
    wr = 1; wway = 1; wadr = mka(32'hC0001, 40); cyc();
    inv_all = 1; cyc();
    repeat (20) cyc();
    rst = 1;
    #1;
    tests++;
    if ({busy, rdy, hit} !== 3'b000) begin
      fails++; $display("FAIL rst_abort got %b exp 000", {busy, rdy, hit});
    end
    mreset();
    @(posedge clk); #1;
    rst = 0;
    just_reset = 1;
    cyc();
    req = 1; adr = mka(32'hC0001, 40); cyc();
    tests++;
    if ({rdy, hit, busy} !== 3'b100) begin
      fails++; $display("FAIL rst_lines_gone got %b exp 100", {rdy, hit, busy});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      req      = 1'($urandom_range(0, 1));
      adr      = mka(32'h3000 + $urandom_range(0, 2), $urandom_range(0, 3));
      wr       = ($urandom_range(0, 2) == 0);
      wadr     = mka(32'h3000 + $urandom_range(0, 2), $urandom_range(0, 3));
      wway     = 2'($urandom_range(0, 3));
      inv_line = ($urandom_range(0, 7) == 0);
      inv_all  = ($urandom_range(0, 199) == 0);
      cyc();
      tests++;
      if ({rdy, hit, rway, multihit, busy} !== {exp_rdy, exp_hit, exp_rway, exp_mh, exp_busy}) begin
        fails++;
        $display("FAIL random[%0d] got %b exp %b", n, {rdy, hit, rway, multihit, busy},
                 {exp_rdy, exp_hit, exp_rway, exp_mh, exp_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_rbw();
    test_multihit_inv();
    test_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
